button_conditioner_bank: RTL and testbench
==========================================

# button_conditioner_bank

Per-channel debouncer and press-event generator for the Nexys A7 push-buttons and CPU_RESETN, sitting between the board pins and the game/SVGA core. Each channel synchronises a raw pad level, applies active-low correction, and requires the new level to hold for 2^CNT_W consecutive clocks before accepting it. It outputs a clean pressed level, one-cycle press/release pulses, and optional auto-repeat press pulses while a button is held. Channel 0 drives the core's synchronous reset; channels 1..5 carry BTNC/U/L/R/D.

## Interface
- N, 6, number of channels
- CNT_W, 16, debounce counter width; stability window = 2^CNT_W clocks (655.36 us at 100 MHz)
- ACTIVE_LOW, 6'b000001, per-channel mask; 1 = pad reads 0 when pressed (bit 0 = CPU_RESETN)
- REPEAT_EN, 6'b111100, per-channel auto-repeat enable (U/L/R/D)
- REPEAT_DELAY, 50_000_000, clocks from press pulse to first repeat pulse (>= 2)
- REPEAT_PERIOD, 10_000_000, clocks between subsequent repeat pulses (>= 2)

- clk  in  1  system clock, 100 MHz (CLK100MHZ)
- rst_n  in  1  asynchronous active-low reset
- btn_raw_i  in  N  raw pad levels, asynchronous to clk
- pressed_o  out  N  debounced level, 1 = pressed
- press_o  out  N  one-cycle pulse: accepted press, and each auto-repeat
- release_o  out  N  one-cycle pulse: accepted release

## Operation
- Input path per channel: raw XOR ACTIVE_LOW[i] -> 2-flop synchroniser (sync1, sync2). Only sync2 feeds logic.
- Debounce per channel: counter cnt[CNT_W-1:0], state bit pressed_o[i].
  - sync2 == pressed_o[i]: cnt <= 0.
  - sync2 != pressed_o[i] and cnt != all-ones: cnt <= cnt + 1.
  - sync2 != pressed_o[i] and cnt == all-ones: pressed_o[i] toggles, cnt <= 0; press_o or release_o pulses on the same edge.
  - Any glitch returning sync2 to pressed_o[i] clears cnt; window restarts. Counter never wraps.
- Repeat FSM per channel, states IDLE, DELAY, REPEAT; counter rcnt of $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)) bits.
  - IDLE: on accepted press, if REPEAT_EN[i] -> DELAY, rcnt <= 0; else stay IDLE.
  - DELAY: rcnt increments; when rcnt == REPEAT_DELAY-1: press_o pulse, -> REPEAT, rcnt <= 0.
  - REPEAT: rcnt increments; when rcnt == REPEAT_PERIOD-1: press_o pulse, rcnt <= 0.
  - Accepted release in any state -> IDLE, rcnt <= 0, same edge as release_o; no repeat pulse on that edge.
- Channels are fully independent; simultaneous events on several channels all reported in the same cycle.
- press_o and release_o for one channel are never asserted together.

## Timing
- Reset (async assert, sync-free deassert handling by the sync flops): sync1, sync2 <= 0 (released after mask), cnt <= 0, rcnt <= 0, FSM IDLE, pressed_o = 0, press_o = 0, release_o = 0.
- Channel held "pressed" at the pad through reset deassertion is accepted as a new press after the normal latency.
- Latency: pad change stable from before edge E -> sync2 valid after E+1 -> pressed_o changes at edge E+1+2^CNT_W (2^CNT_W+2 clocks total counting E). CNT_W=16: 65538 clocks.
- Pulses are registered, exactly one cycle, coincident with the pressed_o transition.
- Repeat: press accepted at edge t -> repeat pulses at t+REPEAT_DELAY, then every REPEAT_PERIOD while held.
- Reset asserted mid-count or mid-repeat: all state cleared immediately; no pulse emitted on the reset cycle or first cycle after.
- Outputs are glitch-free registers; no combinational path from btn_raw_i to any output.

## Test plan
Bench uses CNT_W=4, REPEAT_DELAY=8, REPEAT_PERIOD=4, N=6, default masks.
- Reset, btn_raw_i=6'b000001 held -> all outputs 0 throughout and after reset release; no pulses for 100 clocks.
- BTNC (bit1) rises and holds, raw edge before clock E -> pressed_o[1]=1 and press_o[1] single pulse at E+17; no repeats (REPEAT_EN[1]=0); release after hold -> release_o[1] pulse 18 clocks after raw fall.
- Bit1 bounce: high 10 clocks, low 2, high 30 -> exactly one press pulse, 18 clocks after the final rising raw edge; no pulse from the first burst.
- BTNU (bit2) held 40 clocks after acceptance at t -> press_o[2] at t, t+8, t+12, t+16, ..., t+36; release -> release_o pulse, repeats stop, no press on release edge.
- CPU_RESETN (bit0) driven 0 for 30 clocks -> pressed_o[0]=1 at raw-fall+18, release_o[0] at raw-rise+18; 12-clock low pulse -> no change.
- rst_n asserted while bit3 in REPEAT -> outputs 0 at once; rst_n released with bit3 still pressed -> new press pulse 18 clocks later, repeat restarts from DELAY.

Source files
------------

// File: rtl/button_conditioner_bank_if.sv
// Pad-side and core-side signals for the push-button conditioner bank.
// The master drives raw pad levels. The slave returns the conditioned levels and pulses.
interface button_conditioner_bank_if #(
    parameter int N = 6
);
    logic [N-1:0] btn_raw_i;
    logic [N-1:0] pressed_o;
    logic [N-1:0] press_o;
    logic [N-1:0] release_o;

    modport master (
        output btn_raw_i,
        input  pressed_o,
        input  press_o,
        input  release_o
    );

    modport slave (
        input  btn_raw_i,
        output pressed_o,
        output press_o,
        output release_o
    );
endinterface

// File: rtl/button_conditioner_bank.sv
// Per-channel synchroniser, debouncer and press/release/auto-repeat pulse generator.
//
// state     | meaning
// ST_IDLE   | no repeat activity (released, or repeat disabled for channel)
// ST_DELAY  | held; counting REPEAT_DELAY clocks to the first repeat pulse
// ST_REPEAT | held; emitting a press pulse every REPEAT_PERIOD clocks
module button_conditioner_bank #(
    parameter int           N             = 6,
    parameter int           CNT_W         = 16,
    parameter logic [N-1:0] ACTIVE_LOW    = N'(6'b000001),
    parameter logic [N-1:0] REPEAT_EN     = N'(6'b111100),
    parameter int           REPEAT_DELAY  = 50_000_000,
    parameter int           REPEAT_PERIOD = 10_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    button_conditioner_bank_if.slave bus
);

    localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W = (RMAX > 2) ? $clog2(RMAX) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [RCNT_W-1:0] DLY_M1  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PER_M1  = RCNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    logic [N-1:0]        sync1_q, sync1_d;
    logic [N-1:0]        sync2_q, sync2_d;
    logic [N-1:0]        pressed_q, pressed_d;
    logic [N-1:0]        press_q, press_d;
    logic [N-1:0]        release_q, release_d;
    logic [CNT_W-1:0]    cnt_q  [N];
    logic [CNT_W-1:0]    cnt_d  [N];
    logic [RCNT_W-1:0]   rcnt_q [N];
    logic [RCNT_W-1:0]   rcnt_d [N];
    rpt_state_e          state_q [N];
    rpt_state_e          state_d [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            pressed_q <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i]   <= '0;
                rcnt_q[i]  <= '0;
                state_q[i] <= ST_IDLE;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i]   <= cnt_d[i];
                rcnt_q[i]  <= rcnt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    always_comb begin
        // Polarity is normalised before the synchroniser so every later stage sees 1 = pressed.
        sync1_d   = bus.btn_raw_i ^ ACTIVE_LOW;
        sync2_d   = sync1_q;
        pressed_d = pressed_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i]   = cnt_q[i];
            rcnt_d[i]  = rcnt_q[i];
            state_d[i] = state_q[i];

            if (sync2_q[i] == pressed_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else begin
                cnt_d[i]     = '0;
                pressed_d[i] = ~pressed_q[i];
                if (pressed_q[i]) begin
                    release_d[i] = 1'b1;
                end else begin
                    press_d[i] = 1'b1;
                end
            end

            // A release takes priority, so a repeat pulse due on the release edge is dropped.
            if (release_d[i]) begin
                state_d[i] = ST_IDLE;
                rcnt_d[i]  = '0;
            end else begin
                unique case (state_q[i])
                    ST_IDLE: begin
                        if (press_d[i] && REPEAT_EN[i]) begin
                            state_d[i] = ST_DELAY;
                            rcnt_d[i]  = '0;
                        end
                    end
                    ST_DELAY: begin
                        if (rcnt_q[i] == DLY_M1) begin
                            press_d[i] = 1'b1;
                            state_d[i] = ST_REPEAT;
                            rcnt_d[i]  = '0;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (rcnt_q[i] == PER_M1) begin
                            press_d[i] = 1'b1;
                            rcnt_d[i]  = '0;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        rcnt_d[i]  = '0;
                    end
                endcase
            end
        end
    end

    assign bus.pressed_o = pressed_q;
    assign bus.press_o   = press_q;
    assign bus.release_o = release_q;

endmodule

// File: tb/tb_button_conditioner_bank.sv
// Scoreboard bench for button_conditioner_bank. The stimulus queues the expected pulse events,
// and a monitor checks each press/release pulse against that queue.
module tb_button_conditioner_bank;

    typedef struct {
        int cyc;
        int ch;
        bit rel;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    ev_t  exp_q[$];

    button_conditioner_bank_if #(.N(6)) bif ();

    button_conditioner_bank #(
        .N            (6),
        .CNT_W        (4),
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input int ch, input bit rel);
        ev_t e;
        e.cyc = c;
        e.ch  = ch;
        e.rel = rel;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int ch, input bit rel);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got ch%0d rel=%0b at cyc %0d, required none", ch, rel, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.ch != ch || e.rel != rel) begin
                errors++;
                $display("FAIL pulse_event: got ch%0d rel=%0b cyc %0d, required ch%0d rel=%0b cyc %0d",
                         ch, rel, cyc, e.ch, e.rel, e.cyc);
            end
        end
    endtask

    task automatic check_lvl(input string name, input logic [17:0] act, input logic [17:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    always @(negedge clk) begin
        for (int ch = 0; ch < 6; ch++) begin
            if (bif.press_o[ch] && bif.release_o[ch]) begin
                checks++;
                errors++;
                $display("FAIL exclusive: ch%0d press and release both 1 at cyc %0d, required one", ch, cyc);
            end
            if (bif.press_o[ch])   check_ev(ch, 1'b0);
            if (bif.release_o[ch]) check_ev(ch, 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int t;
        int r;
        rst_n = 1'b0;
        bif.btn_raw_i = 6'b000001;

        // Reset with CPU_RESETN pad high (not pressed); nothing should happen.
        repeat (5) @(negedge clk);
        check_lvl("reset_outputs", {bif.pressed_o, bif.press_o, bif.release_o}, 18'd0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check_lvl("idle_pressed", {12'd0, bif.pressed_o}, 18'd0);

        // BTNC clean press and release
        c = cyc;
        bif.btn_raw_i[1] = 1'b1;
        push(c + 18, 1, 1'b0);
        repeat (30) @(negedge clk);
        check_lvl("btnc_pressed", {12'd0, bif.pressed_o}, 18'b000010);
        c = cyc;
        bif.btn_raw_i[1] = 1'b0;
        push(c + 18, 1, 1'b1);
        repeat (30) @(negedge clk);
        check_lvl("btnc_released", {12'd0, bif.pressed_o}, 18'd0);

        // BTNC bounce: the first burst is too short to be accepted
        bif.btn_raw_i[1] = 1'b1;
        repeat (10) @(negedge clk);
        bif.btn_raw_i[1] = 1'b0;
        repeat (2) @(negedge clk);
        c = cyc;
        bif.btn_raw_i[1] = 1'b1;
        push(c + 18, 1, 1'b0);
        repeat (30) @(negedge clk);
        check_lvl("bounce_pressed", {12'd0, bif.pressed_o}, 18'b000010);
        c = cyc;
        bif.btn_raw_i[1] = 1'b0;
        push(c + 18, 1, 1'b1);
        repeat (30) @(negedge clk);

        // BTNU auto-repeat; the release lands on a would-be repeat edge
        c = cyc;
        bif.btn_raw_i[2] = 1'b1;
        t = c + 18;
        push(t, 2, 1'b0);
        for (int k = 0; k < 8; k++) push(t + 8 + 4 * k, 2, 1'b0);
        wait_until(t + 20);
        check_lvl("btnu_pressed", {12'd0, bif.pressed_o}, 18'b000100);
        wait_until(t + 22);
        bif.btn_raw_i[2] = 1'b0;
        push(t + 40, 2, 1'b1);
        repeat (30) @(negedge clk);
        check_lvl("btnu_released", {12'd0, bif.pressed_o}, 18'd0);

        // CPU_RESETN is active-low at the pad
        c = cyc;
        bif.btn_raw_i[0] = 1'b0;
        push(c + 18, 0, 1'b0);
        repeat (30) @(negedge clk);
        check_lvl("cpurst_pressed", {12'd0, bif.pressed_o}, 18'b000001);
        c = cyc;
        bif.btn_raw_i[0] = 1'b1;
        push(c + 18, 0, 1'b1);
        repeat (30) @(negedge clk);
        check_lvl("cpurst_released", {12'd0, bif.pressed_o}, 18'd0);
        bif.btn_raw_i[0] = 1'b0;
        repeat (12) @(negedge clk);
        bif.btn_raw_i[0] = 1'b1;
        repeat (30) @(negedge clk);
        check_lvl("cpurst_short_ignored", {12'd0, bif.pressed_o}, 18'd0);

        // rst_n asserted while bit3 is repeating, then released with bit3 still held
        c = cyc;
        bif.btn_raw_i[3] = 1'b1;
        t = c + 18;
        push(t, 3, 1'b0);
        push(t + 8, 3, 1'b0);
        push(t + 12, 3, 1'b0);
        wait_until(t + 14);
        check_lvl("bit3_pressed", {12'd0, bif.pressed_o}, 18'b001000);
        rst_n = 1'b0;
        #1;
        check_lvl("reset_immediate", {bif.pressed_o, bif.press_o, bif.release_o}, 18'd0);
        repeat (3) @(negedge clk);
        check_lvl("reset_held", {bif.pressed_o, bif.press_o, bif.release_o}, 18'd0);
        r = cyc;
        rst_n = 1'b1;
        push(r + 18, 3, 1'b0);
        for (int k = 0; k < 6; k++) push(r + 26 + 4 * k, 3, 1'b0);
        wait_until(r + 20);
        check_lvl("bit3_repressed", {12'd0, bif.pressed_o}, 18'b001000);
        wait_until(r + 32);
        bif.btn_raw_i[3] = 1'b0;
        push(r + 50, 3, 1'b1);
        repeat (30) @(negedge clk);
        check_lvl("bit3_released", {12'd0, bif.pressed_o}, 18'd0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected events never seen, required 0 (next ch%0d cyc %0d)",
                     exp_q.size(), exp_q[0].ch, exp_q[0].cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
